spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- SPI-mode-0, write-only slave that holds the configuration register file for the PWM peripheral.
- Samples raw SCLK/COPI/nCS pad inputs (top-level ui_in[0], ui_in[1], ui_in[2]) in the system clock domain.
- Decodes 16-bit write frames and drives the five configuration bytes consumed by the PWM peripheral (output enables, PWM enables, duty cycle).

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (legal: ≥2).
- MAX_ADDR, 7'h04, highest decoded register address; frames above it are discarded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  raw SPI clock (asynchronous to clk)
- copi  input  1  raw SPI data in
- ncs  input  1  raw SPI chip select, active low
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- wr_strobe  output  1  one-clk pulse on each committed write
- frame_err  output  1  one-clk pulse when a frame is discarded

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: all five registers = 8'h00. wr_strobe = 0, frame_err = 0. FSM = IDLE. Bit counter = 0. Shift register = 0. Synchronizers are preset to sclk=0, copi=0, ncs=1.
- Synchronization:
  - Each input passes through SYNC_STAGES flops.
  - Edge detection compares the last synchronizer stage with one extra history flop.
  - All decisions use synchronized values only.
- Timing requirement on the SPI master: SCLK high and low phases each ≥ SYNC_STAGES+2 clk periods. nCS setup/hold to the first/last SCLK edge ≥ SYNC_STAGES+2 clk periods.
- Frame format: 16 bits, MSB first, sampled on synchronized SCLK rising edge.
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
- FSM states:
  - IDLE:
    - Falling edge of synchronized nCS → RECV.
    - On entry to RECV: bit counter cleared, shift register cleared.
  - RECV:
    - Each SCLK rising edge: shift in COPI and increment the counter. The counter saturates at 17 to mark overflow.
    - SCLK edges occurring with nCS high are ignored.
    - Rising edge of nCS → CHECK.
  - CHECK (one clk), the frame is valid iff all of:
    - count == 16
    - bit15 == 1
    - address ≤ MAX_ADDR
    - Valid → COMMIT. Otherwise pulse frame_err for 1 clk → IDLE.
  - COMMIT (one clk): write data to the addressed register, pulse wr_strobe → IDLE.
- Latency: the register output changes exactly 2 clk after the cycle in which the synchronized nCS rising edge is detected (CHECK + COMMIT). Total ≤ SYNC_STAGES+3 clk after the raw nCS rise.
- Error cases:
  - Read frames (bit15 = 0): discarded with frame_err, no register change.
  - Short frames (<16 bits) and long frames (>16 bits): discarded with frame_err.
  - nCS pulse with 0 SCLK edges: discarded with frame_err.
- Registers hold their value indefinitely between frames. Only one register is written per frame.
- nCS falling while in CHECK/COMMIT: the current action completes. The FSM then sees nCS low in IDLE and enters RECV on the next clk, treating it as a new frame start.
- Reset mid-frame: all state and registers return to reset values immediately. The partial frame is lost. After reset deassertion the FSM waits for a fresh nCS falling edge; it must not resume a frame on an already-low nCS.

Test Plan:
- Reset: assert rst_n=0 mid-clock with registers preloaded → all five outputs 8'h00 asynchronously, wr_strobe/frame_err 0.
- Write sweep: frames 0x80F0, 0x81AA, 0x8255, 0x830F, 0x8480 at SCLK = clk/10 → registers read F0, AA, 55, 0F, 80. Exactly five wr_strobe pulses, each 2 clk after the synchronized nCS rise.
- Rejects, each giving one frame_err pulse and no register change from the prior values:
  - read frame 0x0012
  - out-of-range address 0x8533
  - 15-bit frame
  - 17-bit frame
- Back-to-back: two writes 0x84C8 then 0x8419 with minimum nCS high time → duty cycle becomes C8, then 19. Two wr_strobe pulses.
- Reset mid-frame: drop rst_n after 8 bits of 0x8077, release, complete the remaining 8 bits → no write, no strobe. A following full 0x8077 → register 0x00 = 77.
- Glitch immunity: SCLK toggling with nCS high, followed by a valid 0x8101 → only en_reg_out_15_8 = 01, no frame_err.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Write-only SPI (mode 0) slave holding the five configuration bytes of the
// PWM peripheral. Raw pad inputs are synchronised into the clk domain and
// 16-bit frames {R/W, addr[6:0], data[7:0]} are shifted in MSB first on
// synchronised SCLK rising edges. A frame is committed only if exactly 16
// bits arrived, the R/W bit is 1 (write) and the address is <= MAX_ADDR.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   sclk, copi, ncs  raw SPI pad inputs (asynchronous to clk)
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
//   wr_strobe        one-clk pulse, coincident with the register update
//   frame_err        one-clk pulse when a frame is discarded
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int         NUM_REGS   = 5;
  localparam logic [4:0] BITS_FRAME = 5'd16;
  localparam logic [4:0] BITS_OVF   = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_COMMIT
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  // Fills with ones after reset; its last bit says the nCS chain now carries
  // the real pad level instead of the reset preset.
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   sclk_prev_q;
  logic                   ncs_prev_q;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample their inputs from the same pre-edge values; blocking assignments
  // here would collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      flush_q     <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sync_valid;
  logic sclk_rise;
  logic ncs_rise;

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s     = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s      = ncs_sync_q[SYNC_STAGES-1];
  assign sync_valid = flush_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign ncs_rise   = ncs_s & ~ncs_prev_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  // Set once nCS has been seen high (with a flushed synchroniser) since the
  // last frame start. IDLE only starts a frame on a low nCS while armed, so a
  // frame falling during CHECK/COMMIT is still caught, yet a frame that was
  // already in progress across a reset is never resumed.
  logic        armed_q, armed_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        frame_err_q, frame_err_d;

  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_ok;

  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign frame_ok   = (cnt_q == BITS_FRAME) && shift_q[15] &&
                      (frame_addr <= MAX_ADDR);

  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;

    if (sync_valid && ncs_s) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && !ncs_s) begin
          state_d = S_RECV;
          cnt_d   = '0;
          shift_d = '0;
          armed_d = 1'b0;
        end
      end

      S_RECV: begin
        if (ncs_rise) begin
          state_d = S_CHECK;
        end else if (sclk_rise && !ncs_s) begin
          shift_d = {shift_q[14:0], copi_s};
          // Saturating at 17 keeps any overlong frame distinguishable.
          if (cnt_q != BITS_OVF) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_CHECK: begin
        if (frame_ok) begin
          state_d = S_COMMIT;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_COMMIT: begin
        wr_strobe_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [7:0] regs_q [NUM_REGS];

  // NOTE: this small array is a bank of control flops, not a RAM; its reset
  // value is architecturally visible, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == S_COMMIT) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (frame_addr == 7'(i)) begin
          regs_q[i] <= frame_data;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = wr_strobe_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
//
// Self-checking bench for spi_reg_ctrl: a table of directed frames, a few
// hand-written multi-cycle sequences (back-to-back, glitch, resets) and a
// block of random frames checked against a register-file model.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

  localparam int SYNC = 2;
  localparam int HALF = 5;  // SCLK = clk/10

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       frame_err;

  spi_reg_ctrl #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int snap_s = 0;
  int snap_e = 0;

  logic [7:0] model [5];

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      strobe_cnt += int'(wr_strobe);
      err_cnt    += int'(frame_err);
    end
  end

  typedef struct {
    logic [16:0] bits;
    int          nbits;
    bit          exp_valid;
    int          exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'(model[i]));
    end
  endtask

  task automatic snapshot();
    snap_s = strobe_cnt;
    snap_e = err_cnt;
  endtask

  // Shifts nbits of 'bits' MSB first; nCS must already be low with setup met.
  task automatic drive_bits(input logic [16:0] bits, input int nbits,
                            input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
  endtask

  task automatic send_frame(input logic [16:0] bits, input int nbits,
                            input int half);
    ncs = 1'b0;
    repeat (half) @(negedge clk);
    drive_bits(bits, nbits, half);
    ncs = 1'b1;
  endtask

  // Called right after nCS rises (on a negedge). The write must be visible
  // exactly SYNC+3 clk edges later: SYNC synchroniser edges, then edge
  // detection into CHECK, CHECK into COMMIT, and the commit edge itself.
  task automatic finish_frame(input string tag, input bit exp_valid,
                              input int exp_strobes, input int exp_errs);
    repeat (SYNC + 2) @(negedge clk);
    check({tag, "_strobe_early"}, 32'(wr_strobe), 32'd0);
    @(negedge clk);
    check({tag, "_strobe_lat"}, 32'(wr_strobe), 32'(exp_valid));
    check_regs(tag);
    repeat (6) @(negedge clk);
    check({tag, "_n_strobe"}, 32'(strobe_cnt - snap_s), 32'(exp_strobes));
    check({tag, "_n_err"}, 32'(err_cnt - snap_e), 32'(exp_errs));
  endtask

  initial begin
    // Directed table: write sweep then rejects.
    tbl[0] = '{17'h080F0, 16, 1'b1, 0, 8'hF0};
    tbl[1] = '{17'h081AA, 16, 1'b1, 1, 8'hAA};
    tbl[2] = '{17'h08255, 16, 1'b1, 2, 8'h55};
    tbl[3] = '{17'h0830F, 16, 1'b1, 3, 8'h0F};
    tbl[4] = '{17'h08480, 16, 1'b1, 4, 8'h80};
    tbl[5] = '{17'h00012, 16, 1'b0, 0, 8'h00};  // read frame
    tbl[6] = '{17'h08533, 16, 1'b0, 0, 8'h00};  // address 5 out of range
    tbl[7] = '{17'h0412A, 15, 1'b0, 0, 8'h00};  // 15-bit frame
    tbl[8] = '{17'h10353, 17, 1'b0, 0, 8'h00};  // 17-bit frame
    tbl[9] = '{17'h00000, 0,  1'b0, 0, 8'h00};  // nCS pulse, no SCLK

    for (int i = 0; i < 5; i++) model[i] = 8'h00;

    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    repeat (3) @(negedge clk);
    check_regs("reset");
    check("reset_strobe", 32'(wr_strobe), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      snapshot();
      send_frame(tbl[i].bits, tbl[i].nbits, HALF);
      if (tbl[i].exp_valid) model[tbl[i].exp_addr] = tbl[i].exp_data;
      finish_frame($sformatf("tbl%0d", i), tbl[i].exp_valid,
                   tbl[i].exp_valid ? 1 : 0, tbl[i].exp_valid ? 0 : 1);
    end

    // ---- back-to-back with minimum nCS high time ----
    snapshot();
    send_frame(17'h084C8, 16, HALF);
    model[4] = 8'hC8;
    repeat (SYNC + 2) @(negedge clk);
    ncs = 1'b0;
    @(negedge clk);
    check("b2b_first_strobe", 32'(wr_strobe), 32'd1);
    check("b2b_first_duty", 32'(pwm_duty_cycle), 32'h0C8);
    repeat (HALF - 1) @(negedge clk);
    drive_bits(17'h08419, 16, HALF);
    ncs = 1'b1;
    model[4] = 8'h19;
    finish_frame("b2b", 1'b1, 2, 0);

    // ---- SCLK glitching with nCS high, then a valid frame ----
    snapshot();
    for (int i = 0; i < 6; i++) begin
      copi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      sclk = ~sclk;
    end
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    send_frame(17'h08101, 16, HALF);
    model[1] = 8'h01;
    finish_frame("glitch", 1'b1, 1, 0);

    // ---- asynchronous reset with registers preloaded ----
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check_regs("async_rst");
    check("async_rst_strobe", 32'(wr_strobe), 32'd0);
    check("async_rst_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reload one register so the mid-frame reset has something to clear.
    snapshot();
    send_frame(17'h0835A, 16, HALF);
    model[3] = 8'h5A;
    finish_frame("reload", 1'b1, 1, 0);

    // ---- reset in the middle of 0x8077 ----
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    drive_bits(17'h00080, 8, HALF);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check_regs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    snapshot();
    drive_bits(17'h00077, 8, HALF);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_n_strobe", 32'(strobe_cnt - snap_s), 32'd0);
    check("midrst_n_err", 32'(err_cnt - snap_e), 32'd0);
    check_regs("midrst_tail");
    snapshot();
    send_frame(17'h08077, 16, HALF);
    model[0] = 8'h77;
    finish_frame("after_midrst", 1'b1, 1, 0);

    // ---- random frames against the register-file model ----
    for (int n = 0; n < 40; n++) begin
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] w16;
      logic [16:0] bits;
      int          nbits;
      int          sel;
      int          half;
      bit          ok;
      rw    = ($urandom % 4) != 0;
      addr  = 7'($urandom_range(0, 8));
      data  = 8'($urandom);
      sel   = $urandom % 8;
      nbits = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      half  = $urandom_range(SYNC + 2, SYNC + 5);
      w16   = {rw, addr, data};
      if (nbits == 16)      bits = {1'b0, w16};
      else if (nbits == 17) bits = {w16, 1'($urandom)};
      else                  bits = {2'b00, w16[15:1]};
      ok = (nbits == 16) && rw && (addr <= 7'd4);
      if (ok) model[addr] = data;
      snapshot();
      send_frame(bits, nbits, half);
      finish_frame($sformatf("rnd%0d", n), ok, ok ? 1 : 0, ok ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
